sized_data_memory: RTL

- Parametrised, byte-addressed data memory for the MEM stage, successor to the single-cycle word memory.
- Adds byte, half and word loads and stores with per-byte write enables.
- Adds sign or zero extension, misalignment detection, and a configurable access latency behind a req/ready/rvalid handshake.
- The pipeline stalls while ready_o is low.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/sized_data_memory.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the sized data memory: access sizes, FSM states and the
// latched request payload.
package mem_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  typedef struct packed {
    logic            we;
    size_e           size;
    logic            is_unsigned;
    logic [1:0]      lane;
    logic [XLEN-1:0] data;
  } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Lane/size logic: byte enables and replicated store data, load extraction
// with sign/zero extension, and misalignment detection.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e            size,
  input  logic [1:0]       lane,
  input  logic             is_unsigned,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [3:0]       be_c,
  output logic [XLEN-1:0]  wword_c,
  output logic [XLEN-1:0]  rdata_ext_c,
  output logic             misalign_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Move the addressed lane(s) down to bit 0
  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be_c        = 4'b0000;
    wword_c     = wdata;
    rdata_ext_c = '0;
    misalign_c  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be_c        = 4'(4'b0001 << lane);
        wword_c     = {4{wdata[7:0]}};
        rdata_ext_c = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_c        = lane[1] ? 4'b1100 : 4'b0011;
        wword_c     = {2{wdata[15:0]}};
        rdata_ext_c = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        misalign_c  = lane[0];
      end
      SZ_WORD: begin
        be_c        = 4'b1111;
        rdata_ext_c = rdata;
        misalign_c  = |lane;
      end
      default: begin
        be_c        = 4'b0000;
        rdata_ext_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed MEM-stage data memory with byte/half/word access, extension,
// error detection and a fixed access latency behind req/ready/rvalid.
module sized_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              ready_o,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   data_i,
  output logic              rvalid_o,
  output logic [XLEN-1:0]   data_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [XLEN-1:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             rvalid_q, rvalid_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             err_q, err_d;
  req_t             req_q, in_req, op_req;
  logic [IDX_W-1:0] idx_q, in_idx, op_idx;

  logic             accept_c;
  logic             access_c;
  logic             op_err_c;
  logic [3:0]       be_c;
  logic [XLEN-1:0]  wword_c;
  logic [XLEN-1:0]  rdata_ext_c;
  logic             misalign_c;

  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_i[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  assign accept_c = req_i && ready_q;

  always_comb begin
    in_req.we          = we_i;
    in_req.size        = size_e'(size_i);
    in_req.is_unsigned = unsigned_i;
    in_req.lane        = addr_i[1:0];
    in_req.data        = data_i;
    in_idx             = addr_i[IDX_W+1:2];
  end

  // With single-cycle latency the access happens on the accept edge itself
  always_comb begin
    if (LATENCY == 1) begin
      op_req = in_req;
      op_idx = in_idx;
    end else begin
      op_req = req_q;
      op_idx = idx_q;
    end
  end

  mem_lane_align u_align (
    .size        (op_req.size),
    .lane        (op_req.lane),
    .is_unsigned (op_req.is_unsigned),
    .wdata       (op_req.data),
    .rdata       (mem[op_idx]),
    .be_c        (be_c),
    .wword_c     (wword_c),
    .rdata_ext_c (rdata_ext_c),
    .misalign_c  (misalign_c)
  );

  assign op_err_c = misalign_c || (op_req.size == SZ_ILL);

  // Next state, counter and registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    access_c = 1'b0;
    data_d   = '0;
    err_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept_c) begin
          if (LATENCY == 1) begin
            state_d  = DONE;
            access_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          access_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (access_c) begin
      err_d  = op_err_c;
      data_d = (!op_req.we && !op_err_c) ? rdata_ext_c : '0;
    end
    ready_d  = (state_d != WAIT);
    rvalid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      req_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      data_q   <= data_d;
      err_q    <= err_d;
      if (accept_c) begin
        req_q <= in_req;
        idx_q <= in_idx;
      end
    end
  end

  // Storage: contents survive reset; erroneous or reset-aborted stores never land
  always_ff @(posedge clk_i) begin
    if (!rst_i && access_c && op_req.we && !op_err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[op_idx][8*b +: 8] <= wword_c[8*b +: 8];
      end
    end
  end

  assign ready_o  = ready_q;
  assign rvalid_o = rvalid_q;
  assign data_o   = data_q;
  assign err_o    = err_q;

endmodule
